// File: rtl/pattern_sequencer.sv
// Training/validation sample source: writable sample memory split into two partitions,
// per-partition read cursors, epoch counter and learning rate. Define LR_DECAY_EN for lr halving.
module pattern_sequencer #(
  parameter int unsigned      NX      = 4,
  parameter int unsigned      BITS    = 16,
  parameter int unsigned      DEPTH   = 16,
  parameter int unsigned      NTRAIN  = 12,
  parameter logic [BITS-1:0]  LR_INIT = 'h0100,
  parameter int unsigned      LR_STEP = 4,
  parameter logic [BITS-1:0]  LR_MIN  = 'h0008
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       TR,
  input  logic                       VL,
  input  logic                       CLR,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [(NX+1)*BITS-1:0]     wr_data,
  output logic [NX*BITS-1:0]         x,
  output logic [BITS-1:0]            y,
  output logic                       out_valid,
  output logic                       out_mode,
  output logic                       vl_drop,
  output logic [BITS-1:0]            lr,
  output logic [BITS-1:0]            TRAIN,
  output logic [BITS-1:0]            VALID,
  output logic [BITS-1:0]            EPOCH
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned XW   = NX * BITS;
  localparam int unsigned WW   = (NX + 1) * BITS;
  localparam int unsigned NVAL = DEPTH - NTRAIN;

  logic [WW-1:0]   mem_q [DEPTH];

  logic [XW-1:0]   x_q,     x_d;
  logic [BITS-1:0] y_q,     y_d;
  logic            ov_q,    ov_d;
  logic            om_q,    om_d;
  logic            drop_q,  drop_d;
  logic            pend_q,  pend_d;
  logic [BITS-1:0] lr_q,    lr_d;
  logic [BITS-1:0] train_q, train_d;
  logic [BITS-1:0] valid_q, valid_d;
  logic [BITS-1:0] epoch_q, epoch_d;

  logic [AW-1:0]   tr_addr_c;
  logic [AW-1:0]   vl_addr_c;
  logic [WW-1:0]   tr_word_c;
  logic [WW-1:0]   vl_word_c;

`ifdef LR_DECAY_EN
  logic [BITS-1:0] epoch_inc_c;
  logic [BITS-1:0] lr_half_c;
  assign epoch_inc_c = epoch_q + BITS'(1);
  assign lr_half_c   = lr_q >> 1;
`else
  logic unused_params_c;
  assign unused_params_c = ^{LR_STEP, LR_MIN};
`endif

  assign tr_addr_c = AW'(train_q);
  assign vl_addr_c = AW'(NTRAIN) + AW'(valid_q);
  assign tr_word_c = mem_q[tr_addr_c];
  assign vl_word_c = mem_q[vl_addr_c];

  // Sample memory: no reset; a same-edge read sees the old word.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q     <= '0;
      y_q     <= '0;
      ov_q    <= 1'b0;
      om_q    <= 1'b0;
      drop_q  <= 1'b0;
      pend_q  <= 1'b0;
      lr_q    <= LR_INIT;
      train_q <= '0;
      valid_q <= '0;
      epoch_q <= '0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      ov_q    <= ov_d;
      om_q    <= om_d;
      drop_q  <= drop_d;
      pend_q  <= pend_d;
      lr_q    <= lr_d;
      train_q <= train_d;
      valid_q <= valid_d;
      epoch_q <= epoch_d;
    end
  end

  // One service per cycle: CLR > TR > pending VL > new VL.
  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    ov_d    = 1'b0;
    om_d    = om_q;
    drop_d  = 1'b0;
    pend_d  = pend_q;
    lr_d    = lr_q;
    train_d = train_q;
    valid_d = valid_q;
    epoch_d = epoch_q;

    if (CLR) begin
      pend_d  = 1'b0;
      lr_d    = LR_INIT;
      train_d = '0;
      valid_d = '0;
      epoch_d = '0;
    end else if (TR) begin
      x_d  = tr_word_c[XW-1:0];
      y_d  = tr_word_c[WW-1:XW];
      om_d = 1'b0;
      ov_d = 1'b1;
      if (train_q == BITS'(NTRAIN - 1)) begin
        train_d = '0;
        if (epoch_q != '1) begin
          epoch_d = epoch_q + BITS'(1);
`ifdef LR_DECAY_EN
          if ((epoch_inc_c % BITS'(LR_STEP)) == '0) begin
            lr_d = (lr_half_c < LR_MIN) ? LR_MIN : lr_half_c;
          end
`endif
        end
      end else begin
        train_d = train_q + BITS'(1);
      end
      // A VL that cannot be parked in the single pending slot is lost.
      if (VL) begin
        if (pend_q) begin
          drop_d = 1'b1;
        end else begin
          pend_d = 1'b1;
        end
      end
    end else if (pend_q || VL) begin
      x_d  = vl_word_c[XW-1:0];
      y_d  = vl_word_c[WW-1:XW];
      om_d = 1'b1;
      ov_d = 1'b1;
      // Serving the pending request frees the slot for a same-edge VL.
      pend_d  = pend_q & VL;
      valid_d = (valid_q == BITS'(NVAL - 1)) ? '0 : valid_q + BITS'(1);
    end
  end

  assign x         = x_q;
  assign y         = y_q;
  assign out_valid = ov_q;
  assign out_mode  = om_q;
  assign vl_drop   = drop_q;
  assign lr        = lr_q;
  assign TRAIN     = train_q;
  assign VALID     = valid_q;
  assign EPOCH     = epoch_q;

endmodule
